// File: rtl/lsu_pkg.sv
// Shared funct3 size codes, FSM state type and request legality check for the data-memory LSU.
// DMEM_LSU_SUBWORD_STORE_EN decides whether SB/SH are legal (read-modify-write) or rejected.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      ST_IDLE,
      ST_MERGE_WR
   } state_e;

   // Misaligned accesses, unused encodings and unsigned "store" sizes are all rejected
   function automatic logic lsuReqError(input logic [2:0] size, input logic we, input logic [1:0] off);
      logic e;
      e = 1'b0;
      case (size)
         F3_B:    e = 1'b0;
         F3_H:    e = off[0];
         F3_W:    e = (off != 2'b00);
         F3_BU:   e = we;
         F3_HU:   e = we | off[0];
         default: e = 1'b1;
      endcase
`ifndef DMEM_LSU_SUBWORD_STORE_EN
      if (we && ((size == F3_B) || (size == F3_H)))
         e = 1'b1;
`endif
      return e;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a memory word and sign- or zero-extends it.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_byteOff,
   input  logic [2:0]  i_size,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = i_word[7:0];
      case (i_byteOff)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      w_half = i_byteOff[1] ? i_word[31:16] : i_word[15:0];

      o_data = i_word;
      case (i_size)
         F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
         F3_BU:   o_data = {24'd0, w_byte};
         F3_H:    o_data = {{16{w_half[15]}}, w_half};
         F3_HU:   o_data = {16'd0, w_half};
         default: o_data = i_word;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between the pipeline and a word-wide data memory with combinational read.
// Define DMEM_LSU_SUBWORD_STORE_EN to enable SB/SH via read-modify-write; otherwise they are errors.
module dmem_lsu
   import lsu_pkg::*;
#(
   parameter int DMEM_POWER = 18
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [2:0]  mem_memsize,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   state_e                r_state;
   state_e                w_nextState;
   logic                  w_accept;
   logic                  w_err;
   logic                  w_subwordStore;
   logic                  w_memWe;
   logic [31:0]           w_loadData;
   logic [31:0]           w_merged;
   logic [31:0]           r_mergeWord;
   logic [DMEM_POWER-1:0] r_mergeAddr;

   assign req_ready   = (r_state == ST_IDLE);
   assign w_accept    = req_valid & req_ready;
   assign w_err       = lsuReqError(req_size, req_we, req_addr[1:0]);
   assign mem_memsize = req_size;
   assign mem_we      = w_memWe & rst_n;

`ifdef DMEM_LSU_SUBWORD_STORE_EN
   assign w_subwordStore = w_accept & req_we & ~w_err & ((req_size == F3_B) | (req_size == F3_H));
`else
   assign w_subwordStore = 1'b0;
`endif

   lsu_load_align uAlign (
      .i_word    (mem_rd),
      .i_byteOff (req_addr[1:0]),
      .i_size    (req_size),
      .o_data    (w_loadData)
   );

   // Store data lands in the addressed lane of the word just read
   always_comb begin
      w_merged = mem_rd;
      if (req_size == F3_H) begin
         if (req_addr[1])
            w_merged[31:16] = req_wdata[15:0];
         else
            w_merged[15:0]  = req_wdata[15:0];
      end else begin
         case (req_addr[1:0])
            2'd0:    w_merged[7:0]   = req_wdata[7:0];
            2'd1:    w_merged[15:8]  = req_wdata[7:0];
            2'd2:    w_merged[23:16] = req_wdata[7:0];
            default: w_merged[31:24] = req_wdata[7:0];
         endcase
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_memWe     = 1'b0;
      mem_a       = {req_addr[31:2], 2'b00};
      mem_wd      = req_wdata;
      case (r_state)
         ST_IDLE: begin
            w_memWe = w_accept & req_we & ~w_err & (req_size == F3_W);
            if (w_subwordStore)
               w_nextState = ST_MERGE_WR;
         end
         ST_MERGE_WR: begin
            mem_a       = {{(30-DMEM_POWER){1'b0}}, r_mergeAddr, 2'b00};
            mem_wd      = r_mergeWord;
            w_memWe     = 1'b1;
            w_nextState = ST_IDLE;
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Subword stores answer after their merge write; everything else answers the cycle after accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         resp_valid  <= 1'b0;
         resp_rdata  <= 32'd0;
         resp_err    <= 1'b0;
         r_mergeWord <= 32'd0;
         r_mergeAddr <= '0;
      end else begin
         r_state    <= w_nextState;
         resp_valid <= (w_accept & ~w_subwordStore) | (r_state == ST_MERGE_WR);
         resp_err   <= w_accept & w_err;
         resp_rdata <= (w_accept & ~w_err & ~req_we) ? w_loadData : 32'd0;
         if (w_subwordStore) begin
            r_mergeWord <= w_merged;
            r_mergeAddr <= req_addr[DMEM_POWER+1:2];
         end
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: a small word memory model plus a scoreboard of expected responses.
module tb_dmem_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_size = 3'b010;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [2:0]  mem_memsize;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   logic [31:0] mem [0:255];

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t expQ[$];
   int   nChecks = 0;
   int   nFails  = 0;

   dmem_lsu dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_size    (req_size),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .resp_valid  (resp_valid),
      .resp_rdata  (resp_rdata),
      .resp_err    (resp_err),
      .mem_we      (mem_we),
      .mem_memsize (mem_memsize),
      .mem_a       (mem_a),
      .mem_wd      (mem_wd),
      .mem_rd      (mem_rd)
   );

   always #5 clk = ~clk;

   assign mem_rd = mem[mem_a[9:2]];

   always @(posedge clk) begin
      if (mem_we)
         mem[mem_a[9:2]] <= mem_wd;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_addr  = addr;
      req_wdata = wdata;
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      drive(1'b1, 3'b010, addr, data);
      tick();
      req_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      drive(1'b1, 3'b010, 32'h0, 32'hDEAD_BEEF);
      tick();
      nChecks++;
      if (resp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b expected 0", resp_valid); end
      nChecks++;
      if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin nFails++; $display("[TB] FAIL reset_resp: got %0h/%b expected 0/0", resp_rdata, resp_err); end
      nChecks++;
      if (mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
      nChecks++;
      if (req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
      req_valid = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_loads();
      logic [2:0]  sz [4];
      logic [31:0] ad [4];
      logic [31:0] ev [4];
      exp_t        e;
      sz = '{3'b000, 3'b100, 3'b001, 3'b101};
      ad = '{32'h10, 32'h11, 32'h12, 32'h12};
      ev = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_8000, 32'h0000_8000};
      preload(32'h10, 32'h8000_7F80);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, sz[i], ad[i], 32'hFFFF_FFFF);
         expQ.push_back('{rdata: ev[i], err: 1'b0});
         nChecks++;
         if (mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL load%0d_mem_we: got %b expected 0", i, mem_we); end
         tick();
         req_valid = 1'b0;
         nChecks++;
         if (resp_valid !== 1'b1 || expQ.size() == 0) begin
            nFails++; $display("[TB] FAIL load%0d_valid: got %b expected 1", i, resp_valid);
         end
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            nChecks++;
            if (resp_rdata !== e.rdata || resp_err !== e.err) begin
               nFails++; $display("[TB] FAIL load%0d_data: got %0h/%b expected %0h/%b", i, resp_rdata, resp_err, e.rdata, e.err);
            end
         end
         tick();
         nChecks++;
         if (resp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL load%0d_one_cycle: got %b expected 0", i, resp_valid); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int i = 0; i < 4; i++)
         preload(32'(4 * i), 32'hC0DE_0000 + 32'(i * 32'h1111));
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 3'b010, 32'(4 * i), 32'd0);
         expQ.push_back('{rdata: 32'hC0DE_0000 + 32'(i * 32'h1111), err: 1'b0});
         tick();
         nChecks++;
         if (resp_valid !== 1'b1 || expQ.size() == 0) begin
            nFails++; $display("[TB] FAIL b2b%0d_valid: got %b expected 1", i, resp_valid);
         end
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            nChecks++;
            if (resp_rdata !== e.rdata || resp_err !== e.err) begin
               nFails++; $display("[TB] FAIL b2b%0d_data: got %0h/%b expected %0h/%b", i, resp_rdata, resp_err, e.rdata, e.err);
            end
         end
      end
      req_valid = 1'b0;
      tick();
      nChecks++;
      if (resp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_tail: got %b expected 0", resp_valid); end
   endtask

   task automatic test_errors();
      logic        we [5];
      logic [2:0]  sz [5];
      logic [31:0] ad [5];
      exp_t        e;
      we = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      sz = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
      ad = '{32'h22, 32'h23, 32'h21, 32'h0, 32'h4};
      for (int i = 0; i < 5; i++) begin
         drive(we[i], sz[i], ad[i], 32'hFFFF_FFFF);
         expQ.push_back('{rdata: 32'd0, err: 1'b1});
         nChecks++;
         if (mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL err%0d_mem_we: got %b expected 0", i, mem_we); end
         tick();
         req_valid = 1'b0;
         nChecks++;
         if (resp_valid !== 1'b1 || expQ.size() == 0) begin
            nFails++; $display("[TB] FAIL err%0d_valid: got %b expected 1", i, resp_valid);
         end
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            nChecks++;
            if (resp_rdata !== e.rdata || resp_err !== e.err) begin
               nFails++; $display("[TB] FAIL err%0d_data: got %0h/%b expected %0h/%b", i, resp_rdata, resp_err, e.rdata, e.err);
            end
         end
      end
      nChecks++;
      if (mem[1] !== 32'hC0DE_1111) begin nFails++; $display("[TB] FAIL err_mem_kept: got %0h expected c0de1111", mem[1]); end
   endtask

`ifdef DMEM_LSU_SUBWORD_STORE_EN
   task automatic test_subword_store();
      exp_t e;
      preload(32'h20, 32'h1122_3344);
      drive(1'b1, 3'b000, 32'h21, 32'h1234_56AA);
      expQ.push_back('{rdata: 32'd0, err: 1'b0});
      nChecks++;
      if (mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL sb_c1_mem_we: got %b expected 0", mem_we); end
      tick();
      req_valid = 1'b0;
      nChecks++;
      if (req_ready !== 1'b0) begin nFails++; $display("[TB] FAIL sb_c2_ready: got %b expected 0", req_ready); end
      nChecks++;
      if (mem_we !== 1'b1 || mem_a !== 32'h20 || mem_wd !== 32'h1122_AA44) begin
         nFails++; $display("[TB] FAIL sb_c2_write: got %b/%0h/%0h expected 1/20/1122aa44", mem_we, mem_a, mem_wd);
      end
      nChecks++;
      if (resp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL sb_c2_valid: got %b expected 0", resp_valid); end
      tick();
      nChecks++;
      if (resp_valid !== 1'b1 || expQ.size() == 0) begin
         nFails++; $display("[TB] FAIL sb_c3_valid: got %b expected 1", resp_valid);
      end
      if (expQ.size() != 0) begin
         e = expQ.pop_front();
         nChecks++;
         if (resp_rdata !== e.rdata || resp_err !== e.err) begin
            nFails++; $display("[TB] FAIL sb_c3_data: got %0h/%b expected %0h/%b", resp_rdata, resp_err, e.rdata, e.err);
         end
      end
      nChecks++;
      if (mem[8] !== 32'h1122_AA44) begin nFails++; $display("[TB] FAIL sb_mem: got %0h expected 1122aa44", mem[8]); end
      nChecks++;
      if (mem_we !== 1'b0 || req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL sb_c3_idle: got %b/%b expected 0/1", mem_we, req_ready); end
      tick();
   endtask

   task automatic test_reset_merge();
      preload(32'h30, 32'h1234_5678);
      drive(1'b1, 3'b001, 32'h30, 32'h0000_BEEF);
      tick();
      req_valid = 1'b0;
      nChecks++;
      if (req_ready !== 1'b0 || mem_we !== 1'b1) begin nFails++; $display("[TB] FAIL rstm_in_merge: got %b/%b expected 0/1", req_ready, mem_we); end
      rst_n = 1'b0;
      #1;
      nChecks++;
      if (mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL rstm_mem_we: got %b expected 0", mem_we); end
      nChecks++;
      if (resp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rstm_valid: got %b expected 0", resp_valid); end
      tick();
      rst_n = 1'b1;
      tick();
      nChecks++;
      if (resp_valid !== 1'b0) begin nFails++; $display("[TB] FAIL rstm_no_resp: got %b expected 0", resp_valid); end
      nChecks++;
      if (req_ready !== 1'b1) begin nFails++; $display("[TB] FAIL rstm_ready: got %b expected 1", req_ready); end
      nChecks++;
      if (mem[12] !== 32'h1234_5678) begin nFails++; $display("[TB] FAIL rstm_mem: got %0h expected 12345678", mem[12]); end
   endtask
`else
   task automatic test_subword_disabled();
      exp_t e;
      preload(32'h40, 32'h5566_7788);
      drive(1'b1, 3'b000, 32'h40, 32'h0000_00AA);
      expQ.push_back('{rdata: 32'd0, err: 1'b1});
      nChecks++;
      if (mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL sbdis_mem_we: got %b expected 0", mem_we); end
      tick();
      req_valid = 1'b0;
      nChecks++;
      if (resp_valid !== 1'b1 || expQ.size() == 0) begin
         nFails++; $display("[TB] FAIL sbdis_valid: got %b expected 1", resp_valid);
      end
      if (expQ.size() != 0) begin
         e = expQ.pop_front();
         nChecks++;
         if (resp_rdata !== e.rdata || resp_err !== e.err) begin
            nFails++; $display("[TB] FAIL sbdis_data: got %0h/%b expected %0h/%b", resp_rdata, resp_err, e.rdata, e.err);
         end
      end
      nChecks++;
      if (req_ready !== 1'b1 || mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL sbdis_idle: got %b/%b expected 1/0", req_ready, mem_we); end
      tick();
      nChecks++;
      if (mem[16] !== 32'h5566_7788) begin nFails++; $display("[TB] FAIL sbdis_mem: got %0h expected 55667788", mem[16]); end
   endtask
`endif

   // Runs every scenario in order, then reports the tally
   initial begin
      test_reset();
      test_loads();
      test_back_to_back();
      test_errors();
`ifdef DMEM_LSU_SUBWORD_STORE_EN
      test_subword_store();
      test_reset_merge();
`else
      test_subword_disabled();
`endif
      nChecks++;
      if (expQ.size() != 0) begin nFails++; $display("[TB] FAIL scoreboard_drain: got %0d expected 0", expQ.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   // Guards against a hang if the design never lets the sequence progress
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DMEM_POWER, default 18, giving log2 of the data memory depth in 32-bit words.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1, pipeline memory request present.
REQ-005 SHALL have port req_ready, output, 1, request accepted when req_valid && req_ready.
REQ-006 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 3, RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have ports req_addr and req_wdata, input, 32 each, byte address and store data (right-justified).
REQ-009 SHALL have ports resp_valid (output, 1), resp_rdata (output, 32, extended load data) and resp_err (output, 1, misaligned or illegal size).
REQ-010 SHALL have memory-side ports mem_we (output, 1), mem_memsize (output, 3, copy of req_size), mem_a (output, 32), mem_wd (output, 32) and mem_rd (input, 32, combinational word read of mem_a).

Function
REQ-011 SHALL implement FSM states IDLE and MERGE_WR; req_ready = 1 only in IDLE.
REQ-012 SHALL drive mem_a = {req_addr[31:2], 2'b00} in IDLE and the latched word address in MERGE_WR.
REQ-013 SHALL flag an error for: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0; size 011, 110 or 111; store size 100 or 101.
REQ-014 SHALL, on an accepted erroring request, assert no mem_we and then give resp_valid=1, resp_err=1, resp_rdata=0 on the next cycle.
REQ-015 SHALL complete a load in 1 cycle: select byte/half from mem_rd by addr[1:0], sign-extend (B, H) or zero-extend (BU, HU), register it, and assert resp_valid the next cycle.
REQ-016 SHALL complete an aligned SW in 1 cycle: mem_we=1 and mem_wd=req_wdata in the accept cycle, resp_valid (rdata 0) the next cycle.
REQ-017 SHALL perform SB/SH as read-modify-write: in the accept cycle, read mem_rd, merge req_wdata[7:0]/[15:0] into the addressed lane, latch the word, and go to MERGE_WR.
REQ-018 SHALL, in MERGE_WR, drive mem_we=1 with the merged word, return to IDLE, and assert resp_valid the following cycle (2-cycle latency).
REQ-019 SHALL hold resp_valid for exactly one cycle per accepted request; there is no response backpressure.
REQ-020 SHALL accept a new request in the same cycle a previous resp_valid is high, giving 1 load per cycle throughput.
REQ-021 SHALL keep mem_we=0 whenever req_valid=0 in IDLE.

Reset
REQ-022 SHALL, on rst_n=0, force state to IDLE and resp_valid, resp_rdata, resp_err and the merge register to 0 immediately.
REQ-023 SHALL hold mem_we at 0 combinationally while rst_n=0; a reset in MERGE_WR aborts the write, leaving memory unchanged, with no response.

Configuration
REQ-024 SHALL support macro DMEM_LSU_SUBWORD_STORE_EN: when defined, SB/SH use the read-modify-write of REQ-017/018.
REQ-025 SHALL, when DMEM_LSU_SUBWORD_STORE_EN is undefined, omit MERGE_WR and flag SB/SH as errors per REQ-014, with no write performed.

Structure
REQ-026 SHALL take funct3 size encodings and the FSM state enum from a shared package, lsu_pkg.
REQ-027 SHALL implement load lane select and extension in one combinational sub-module, lsu_load_align.

Verification
REQ-028 SHALL cover: mem word 0x8000_7F80 at 0x10; LB 0x10 -> rdata 0xFFFF_FF80; LBU 0x11 -> 0x0000_007F; LH 0x12 -> 0xFFFF_8000; LHU 0x12 -> 0x0000_8000; each resp_valid 1 cycle after accept.
REQ-029 SHALL cover: word 0x1122_3344 at 0x20, SB 0xAA to 0x21 -> mem_we in cycle 2 only, memory 0x1122_AA44, resp_valid cycle 3, req_ready=0 in cycle 2.
REQ-030 SHALL cover: LW 0x22, SH 0x23, SW 0x21 and size 011 -> resp_err=1, rdata 0, no mem_we asserted.
REQ-031 SHALL cover: 4 back-to-back LWs at 0x0, 0x4, 0x8, 0xC -> 4 consecutive resp_valid cycles with correct data.
REQ-032 SHALL cover: rst_n low in MERGE_WR of SH 0xBEEF to 0x30 -> memory unchanged, no resp_valid, req_ready=1 after release.
REQ-033 SHALL cover: build without DMEM_LSU_SUBWORD_STORE_EN, SB to 0x40 -> resp_err=1, memory unchanged.
